// File: rtl/deserializer.sv
// LSB-first serial-to-parallel receiver with a valid/ack holding register.
// Optional trailing even-parity bit per frame is enabled by DESERIALIZER_PARITY_EN.
module deserializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int COUNTER_SIZE = clog2(DATA_WIDTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic                  busy,
    output logic                  frame_error,
    output logic                  overrun,
    output logic                  parity_error
);

    function automatic int clog2(input int value);
        int result;
        for (result = 0; (1 << result) < value; result++) begin
        end
        return result;
    endfunction

`ifdef DESERIALIZER_PARITY_EN
    localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = DATA_WIDTH;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [COUNTER_SIZE-1:0] count;

    logic [DATA_WIDTH:0]     joined;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]   word;
    logic [COUNTER_SIZE-1:0] next_count;
    logic                    last_bit;
    logic                    sample_data;
    logic                    word_ok;

    // Count of bits received including the one on data_in this cycle.
    always_comb begin
        joined     = {data_in, shift_reg};
        shifted    = joined[DATA_WIDTH:1];
        next_count = (state == IDLE) ? COUNTER_SIZE'(1) : count + COUNTER_SIZE'(1);
        last_bit   = (next_count == COUNTER_SIZE'(FRAME_LEN));
`ifdef DESERIALIZER_PARITY_EN
        // The parity bit is checked against the stored data, never shifted in.
        sample_data = (next_count <= COUNTER_SIZE'(DATA_WIDTH));
        word        = shift_reg;
        word_ok     = ((^shift_reg) == data_in);
`else
        sample_data = 1'b1;
        word        = shifted;
        word_ok     = 1'b1;
`endif
    end

    assign busy = (state == SHIFT);

`ifndef DESERIALIZER_PARITY_EN
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            count       <= '0;
            data_out    <= '0;
            out_valid   <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
            parity_error <= 1'b0;
`endif
        end else begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
            parity_error <= 1'b0;
`endif
            if (out_valid && out_ack) begin
                out_valid <= 1'b0;
            end

            if (data_valid) begin
                if (sample_data) begin
                    shift_reg <= shifted;
                end
                if (last_bit) begin
                    state <= IDLE;
                    count <= '0;
                    if (word_ok) begin
                        // An ack on the completion edge frees the register for the new word.
                        if (!out_valid || out_ack) begin
                            data_out  <= word;
                            out_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
`ifdef DESERIALIZER_PARITY_EN
                        parity_error <= 1'b1;
`endif
                    end
                end else begin
                    state <= SHIFT;
                    count <= next_count;
                end
            end else if (state == SHIFT) begin
                frame_error <= 1'b1;
                state       <= IDLE;
                count       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer; also exercises the parity
// frame format when DESERIALIZER_PARITY_EN is defined.
module tb_deserializer;

`ifdef DESERIALIZER_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       data_in;
    logic       data_valid;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ack;
    logic       busy;
    logic       frame_error;
    logic       overrun;
    logic       parity_error;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    deserializer #(.DATA_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .out_ack      (out_ack),
        .busy         (busy),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .parity_error (parity_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        data_in    = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input bit ack_last, input bit chk_busy);
        for (int i = 0; i < n; i++) begin
            data_valid = 1'b1;
            data_in    = bits[i];
            out_ack    = ack_last && (i == n - 1);
            step();
            if (chk_busy) check($sformatf("busy_bit%0d", i + 1), busy, (i < n - 1));
        end
        out_ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] w, input bit ack_last, input bit chk_busy);
        logic [15:0] bits;
        bits = {8'h00, w};
`ifdef DESERIALIZER_PARITY_EN
        bits[8] = ^w;
`endif
        send_bits(bits, FRAME, ack_last, chk_busy);
    endtask

    task automatic ack_word();
        logic [7:0] exp;
        check("exp_q_nonempty", exp_q.size() != 0, 1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        check("ack_valid_before", out_valid, 1);
        check("ack_data", data_out, exp);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        check("ack_valid_after", out_valid, 0);
    endtask

    initial begin
        reset      = 1'b1;
        data_in    = 1'b0;
        data_valid = 1'b0;
        out_ack    = 1'b0;
        repeat (2) step();
        check("rst_data", data_out, 8'h00);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_error, 0);
        check("rst_ovr", overrun, 0);
        check("rst_perr", parity_error, 0);
        reset = 1'b0;
        step();

        // Single word with busy tracked every bit and zero-cycle latency.
        send_frame(8'hA5, 1'b0, 1'b1);
        check("a5_valid", out_valid, 1);
        check("a5_data", data_out, 8'hA5);
        exp_q.push_back(8'hA5);
        idle(1);
        ack_word();

        // Ack with nothing pending has no effect.
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        check("stray_ack_valid", out_valid, 0);

        // Overrun: second word dropped while first is unacknowledged.
        send_frame(8'h3C, 1'b0, 1'b0);
        check("3c_ovr", overrun, 0);
        exp_q.push_back(8'h3C);
        idle(1);
        send_frame(8'hC3, 1'b0, 1'b0);
        check("c3_ovr_pulse", overrun, 1);
        check("c3_keep_old", data_out, 8'h3C);
        idle(1);
        check("c3_ovr_clear", overrun, 0);
        ack_word();

        // Truncated frame while a word is pending.
        send_frame(8'h11, 1'b0, 1'b0);
        exp_q.push_back(8'h11);
        idle(1);
        send_bits(16'h0015, 5, 1'b0, 1'b0);
        check("trunc_busy", busy, 1);
        idle(1);
        check("trunc_ferr", frame_error, 1);
        check("trunc_busy_off", busy, 0);
        check("trunc_valid", out_valid, 1);
        check("trunc_data", data_out, 8'h11);
        idle(1);
        check("trunc_ferr_clear", frame_error, 0);
        ack_word();
        send_frame(8'h81, 1'b0, 1'b0);
        exp_q.push_back(8'h81);
        idle(1);
        ack_word();

        // Back-to-back frames, ack on the second completion edge.
        send_frame(8'hFF, 1'b0, 1'b0);
        check("b2b_ff_valid", out_valid, 1);
        check("b2b_ff_data", data_out, 8'hFF);
        send_frame(8'h00, 1'b1, 1'b0);
        check("b2b_00_valid", out_valid, 1);
        check("b2b_00_data", data_out, 8'h00);
        check("b2b_ovr", overrun, 0);
        exp_q.push_back(8'h00);
        idle(1);
        check("b2b_ovr_late", overrun, 0);
        ack_word();

        // Reset mid-frame with a pending word.
        send_frame(8'h24, 1'b0, 1'b0);
        send_bits(16'h0009, 4, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ferr", frame_error, 0);
        check("mid_rst_ovr", overrun, 0);
        reset      = 1'b0;
        data_valid = 1'b0;
        step();
        check("post_rst_ferr", frame_error, 0);
        send_frame(8'h5A, 1'b0, 1'b0);
        exp_q.push_back(8'h5A);
        idle(1);
        ack_word();

`ifdef DESERIALIZER_PARITY_EN
        // 8'h07 has three ones, so even parity bit is 1.
        send_bits(16'h0107, 9, 1'b0, 1'b0);
        check("par_ok_perr", parity_error, 0);
        exp_q.push_back(8'h07);
        idle(1);
        ack_word();
        send_bits(16'h0007, 9, 1'b0, 1'b0);
        check("par_bad_perr", parity_error, 1);
        check("par_bad_valid", out_valid, 0);
        check("par_bad_ovr", overrun, 0);
        idle(1);
        check("par_perr_clear", parity_error, 0);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
Serial-to-parallel receiver that sits directly downstream of the serializer stage. It samples a 1-bit LSB-first serial stream, framed by an enable (normally wired to the serializer's busy output), and assembles DATA_WIDTH-bit words. Completed words go to a holding register with a valid/ack handshake toward the parallel consumer. Truncated frames and overruns are flagged.

Parameters:
DATA_WIDTH, 8, word width in bits; also the frame length in serial bits.
COUNTER_SIZE, clog2(DATA_WIDTH)+1, bit-counter width; clog2 is a local function.

Ports:
clock  input  1  single system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  1  serial bit, sampled only when data_valid=1.
data_valid  input  1  frame enable; high for exactly DATA_WIDTH consecutive cycles per word.
data_out  output  DATA_WIDTH  holding register, bit 0 = first bit received.
out_valid  output  1  data_out holds an unconsumed word.
out_ack  input  1  consumer accepts the word; acts only when out_valid=1.
busy  output  1  a frame is partially received.
frame_error  output  1  one-cycle pulse: frame truncated.
overrun  output  1  one-cycle pulse: completed word dropped.
parity_error  output  1  one-cycle pulse: parity mismatch. Tied 0 without the optional feature.

Behaviour:
- Reset (synchronous, on a clock edge with reset=1): state=IDLE, shift register=0, counter=0, data_out=0, out_valid=0, busy=0, all pulses=0. Reset overrides everything, including mid-frame and pending out_valid; a partial frame is discarded silently.
- Shift register: on each sampled bit, shift right and insert data_in at the MSB. After DATA_WIDTH samples, bit 0 holds the first bit received.
- FSM states are IDLE and SHIFT.
  - IDLE, data_valid=1: sample bit, counter=1, go to SHIFT. With DATA_WIDTH=1, the word completes immediately.
  - IDLE, data_valid=0: hold.
  - SHIFT, data_valid=1: sample bit, counter+1. When the counter reaches DATA_WIDTH, the word is complete and the FSM returns to IDLE.
  - SHIFT, data_valid=0 before completion: frame_error=1 next cycle, discard the bits, go to IDLE, data_out unchanged.
- Back-to-back frames: data_valid held high past the last bit starts a new frame on the next cycle with no idle gap required. The serializer always inserts at least one idle cycle, but the deserializer still supports zero gap.
- busy=1 exactly while state=SHIFT.
- Latency: the last bit is sampled at edge k; data_out and out_valid update at edge k (visible in the cycle after k).
- Handshake:
  - out_valid clears on the edge where out_valid=1 and out_ack=1.
  - out_ack while out_valid=0 is ignored.
- Completion with out_valid=0: load data_out, set out_valid=1.
- Completion with out_valid=1 and out_ack=1 on the same edge: load the new word, out_valid stays 1, no overrun.
- Completion with out_valid=1 and out_ack=0: keep the old word, drop the new one, overrun=1 for one cycle.
- Counter never wraps; it is cleared on every return to IDLE.

Optional Feature:
Macro DESERIALIZER_PARITY_EN.
- Defined: the frame is DATA_WIDTH+1 bits; the last bit is even parity over the data bits and is not shifted into the word.
  - Parity mismatch: parity_error=1 for one cycle, word discarded, out_valid unchanged, no overrun.
  - A frame truncated before the parity bit raises frame_error.
- Undefined: no parity bit, parity_error driven constant 0, frame is exactly DATA_WIDTH bits.

Test Plan:
- Reset, then drive 8'hA5 LSB-first (1,0,1,0,0,1,0,1) with data_valid high for 8 cycles -> out_valid=1 and data_out=8'hA5 in the cycle after the 8th edge; busy high for cycles 2-8.
- Hold out_ack=0, send 8'h3C then 8'hC3 -> data_out stays 8'h3C, overrun pulses once at the 8'hC3 completion; then out_ack=1 -> out_valid=0.
- Drop data_valid after 5 bits -> frame_error one cycle, busy=0, out_valid unchanged; next full frame 8'h81 received correctly.
- Back-to-back 8'hFF then 8'h00 with data_valid continuously high for 16 cycles, ack asserted on the completion edge -> both words delivered, no overrun.
- Assert reset at bit 4 of a frame with out_valid=1 -> next cycle all outputs 0; following frame 8'h5A received normally.
- With DESERIALIZER_PARITY_EN: 8'h07 plus parity bit 1 -> word delivered; same word with parity bit 0 -> parity_error pulse, out_valid stays 0.
